regalu_sequencer: RTL and testbench
===================================

Name: regalu_sequencer

Overview:
- Multi-cycle controller that accepts 16-bit instructions over a valid/ready handshake and sequences the register-file/ALU datapath: IDLE -> DECODE -> EXEC -> WB.
- Decodes each instruction into the following datapath controls:
  - register addresses;
  - ALU opcode;
  - immediate and immediate-select;
  - tri-state output enable;
  - register write enable.
- Holds the architectural flag register, updated per opcode class.
- Sits between instruction fetch (upstream) and the RegFile/ALU/tri-state datapath (downstream).

Parameters:
- DATA_W, 16, datapath and immediate width.
- REG_AW, 4, register address width (16 registers).
- OP_W, 5, ALU opcode width.
- FLAG_W, 5, flag width; bit order {C,L,F,Z,N} = [4:0].

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Rst  in  1  synchronous, active-high reset.
- instr  in  16  instruction word; sampled when instr_valid && instr_ready.
- instr_valid  in  1  upstream has an instruction.
- instr_ready  out  1  high only in IDLE.
- alu_flags  in  FLAG_W  live flags from the ALU.
- RdestRegLoc  out  REG_AW  destination/first operand register.
- RsrcRegLoc  out  REG_AW  source register.
- Imm  out  DATA_W  extended immediate.
- Imm_s  out  1  1 = ALU Rsrc operand comes from Imm.
- OpCode  out  OP_W  ALU operation.
- buf_en  out  1  tri-state buffer enable (ALU result onto write bus).
- En  out  1  register-file write enable.
- flags  out  FLAG_W  architectural flag register.
- done  out  1  one-cycle pulse at end of WB.
- illegal  out  1  one-cycle pulse when an undecodable instruction is dropped.

Behaviour:
- Reset (synchronous, Rst=1 at a rising edge):
  - state = IDLE;
  - all outputs 0 except instr_ready = 1;
  - flags = 0.
  - Reset mid-operation aborts the instruction: no write, no flag update, no done.
- Instruction format:
  - [15:12] major op; [11:8] Rdest.
  - R-type (major = 0000): [7:4] ext selects the operation; [3:0] Rsrc.
  - I-type: [7:0] imm8.
- Operation codes (ext for R-type, major for I-type):
  - 0101 ADD; 1001 SUB; 1011 CMP;
  - 0001 AND; 0010 OR; 0011 XOR;
  - 1101 MOV.
- Immediate extension:
  - ADDI/SUBI/CMPI/MOVI: Imm = sign-extended imm8.
  - ANDI/ORI/XORI: Imm = zero-extended imm8.
  - R-type: Imm = 0.
- State machine:
  - IDLE:
    - instr_ready = 1;
    - on instr_valid, latch instr and go to DECODE;
    - otherwise stay.
  - DECODE:
    - register RdestRegLoc, RsrcRegLoc, Imm, Imm_s, OpCode from the latched instruction;
    - illegal code: pulse illegal and return to IDLE; no datapath outputs change;
    - else go to EXEC.
  - EXEC:
    - buf_en = 1; ALU settles;
    - go to WB.
  - WB:
    - buf_en = 1;
    - En = 1 unless the op is CMP;
    - flag update per op:
      - ADD/SUB load C and F from alu_flags; L, Z, N unchanged.
      - CMP loads L, Z, N; C, F unchanged.
      - Logic ops and MOV leave flags unchanged.
    - done = 1; go to IDLE.
- Datapath controls (Rdest/Rsrc/Imm/Imm_s/OpCode) hold stable from DECODE through WB and keep their last values in IDLE.
- En and buf_en are 0 outside the states listed above.
- Latency: accept edge -> done high 3 cycles later.
- Throughput: one instruction per 4 cycles; instr_ready rises in the cycle after done.
- instr_valid while instr_ready = 0 is ignored; upstream must hold instr until accepted.
- Back-to-back valid: the next instruction is accepted in the first IDLE cycle.
- Rdest == Rsrc is legal and needs no special handling.

Decomposition:
- Package regalu_pkg holds:
  - state enum (IDLE, DECODE, EXEC, WB);
  - major/ext code constants;
  - ALU OpCode constants: ADD=0, SUB=1, CMP=2, AND=3, OR=4, XOR=5, MOV=6;
  - flag bit index constants.
- Sub-module regalu_decode (combinational) maps instr to {OpCode, Imm, Imm_s, writes_reg, flag_mask, illegal}.
- The FSM and flag register stay in regalu_sequencer.

Test Plan:
- Reset then idle: Rst high 2 cycles, release -> instr_ready = 1, flags = 0, En = buf_en = done = 0.
- R-type ADD:
  - stimulus: instr = 0x0352 (ADD R3,R2) valid at cycle t;
  - at t+1: RdestRegLoc = 3, RsrcRegLoc = 2, Imm_s = 0, OpCode = 0;
  - at t+3: En = 1, done = 1;
  - with alu_flags = 5'b10100: flags = 5'b10100.
- SUBI sign-extension: instr = 0x94FF -> Imm = 0xFFFF, Imm_s = 1, OpCode = 1.
- ANDI zero-extension: instr = 0x14FF -> Imm = 0x00FF.
- CMP: instr = 0x01B2 with alu_flags = 5'b01011 -> En never asserted; flags L, Z, N = 1,1,1; C, F unchanged.
- Illegal code: instr = 0x7123 -> illegal pulses at t+1, back in IDLE at t+2, no En, flags unchanged.
- Reset mid-op: Rst asserted during EXEC -> next cycle IDLE, En = 0, no done, flags = 0.
- Handshake: instr_valid held high continuously -> accepts every 4th cycle, instr_ready low for 3 cycles after each accept.

Source files
------------

// File: rtl/regalu_pkg.sv
// regalu_pkg: shared state encoding, instruction codes, ALU opcodes and flag layout for the regalu sequencer
package regalu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;
  localparam logic [3:0] C_RTYPE = 4'b0000;
  localparam logic [3:0] C_ADD   = 4'b0101;
  localparam logic [3:0] C_SUB   = 4'b1001;
  localparam logic [3:0] C_CMP   = 4'b1011;
  localparam logic [3:0] C_AND   = 4'b0001;
  localparam logic [3:0] C_OR    = 4'b0010;
  localparam logic [3:0] C_XOR   = 4'b0011;
  localparam logic [3:0] C_MOV   = 4'b1101;
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_CMP = 2;
  localparam int OP_AND = 3;
  localparam int OP_OR  = 4;
  localparam int OP_XOR = 5;
  localparam int OP_MOV = 6;
  localparam int F_C = 4;
  localparam int F_L = 3;
  localparam int F_F = 2;
  localparam int F_Z = 1;
  localparam int F_N = 0;
  localparam logic [4:0] M_ARITH = (5'd1 << F_C) | (5'd1 << F_F);
  localparam logic [4:0] M_CMP   = (5'd1 << F_L) | (5'd1 << F_Z) | (5'd1 << F_N);
endpackage

// File: rtl/regalu_decode.sv
// regalu_decode: combinational instruction decode into ALU opcode, immediate, write/flag controls
//   i_instr      16-bit instruction word
//   o_opcode     ALU operation
//   o_imm        extended immediate (0 for R-type)
//   o_imm_s      ALU second operand comes from the immediate
//   o_writes_reg op writes its destination register
//   o_flag_mask  flag bits the op loads from the ALU
//   o_illegal    instruction is undecodable
module regalu_decode
  import regalu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 5,
  parameter int FLAG_W = 5
) (
  input  logic [15:0]       i_instr,
  output logic [OP_W-1:0]   o_opcode,
  output logic [DATA_W-1:0] o_imm,
  output logic              o_imm_s,
  output logic              o_writes_reg,
  output logic [FLAG_W-1:0] o_flag_mask,
  output logic              o_illegal
);
  logic       w_rtype;
  logic [3:0] w_code;
  logic       w_sext;
  assign w_rtype      = i_instr[15:12] == C_RTYPE;
  assign w_code       = w_rtype ? i_instr[7:4] : i_instr[15:12];
  assign o_imm_s      = !w_rtype;
  assign o_writes_reg = w_code != C_CMP;
  // Logic ops zero-extend so masks keep their upper bits clear; arithmetic and MOV sign-extend.
  assign o_imm = w_rtype ? '0
               : w_sext  ? {{(DATA_W-8){i_instr[7]}}, i_instr[7:0]}
               :           {{(DATA_W-8){1'b0}}, i_instr[7:0]};
  always_comb begin
    o_opcode    = '0;
    o_flag_mask = '0;
    o_illegal   = 1'b0;
    w_sext      = 1'b0;
    case (w_code)
      C_ADD: begin o_opcode = OP_W'(OP_ADD); w_sext = 1'b1; o_flag_mask = FLAG_W'(M_ARITH); end
      C_SUB: begin o_opcode = OP_W'(OP_SUB); w_sext = 1'b1; o_flag_mask = FLAG_W'(M_ARITH); end
      C_CMP: begin o_opcode = OP_W'(OP_CMP); w_sext = 1'b1; o_flag_mask = FLAG_W'(M_CMP); end
      C_AND: o_opcode = OP_W'(OP_AND);
      C_OR:  o_opcode = OP_W'(OP_OR);
      C_XOR: o_opcode = OP_W'(OP_XOR);
      C_MOV: begin o_opcode = OP_W'(OP_MOV); w_sext = 1'b1; end
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/regalu_sequencer.sv
// regalu_sequencer: IDLE->DECODE->EXEC->WB controller driving the register-file/ALU datapath and holding the flag register
//   Clk, Rst                  clock, synchronous active-high reset
//   instr/instr_valid/instr_ready  instruction handshake (ready only in IDLE)
//   alu_flags                 live ALU flags {C,L,F,Z,N}
//   RdestRegLoc/RsrcRegLoc/Imm/Imm_s/OpCode  datapath controls, held from DECODE through WB
//   buf_en, En                tri-state enable (EXEC, WB), register write enable (WB, non-CMP)
//   flags                     architectural flags
//   done, illegal             end-of-WB pulse, dropped-instruction pulse
module regalu_sequencer
  import regalu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int OP_W   = 5,
  parameter int FLAG_W = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [REG_AW-1:0] RdestRegLoc,
  output logic [REG_AW-1:0] RsrcRegLoc,
  output logic [DATA_W-1:0] Imm,
  output logic              Imm_s,
  output logic [OP_W-1:0]   OpCode,
  output logic              buf_en,
  output logic              En,
  output logic [FLAG_W-1:0] flags,
  output logic              done,
  output logic              illegal
);
  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_instr;
  logic [15:0]       w_dec_in;
  logic [OP_W-1:0]   w_opcode;
  logic [DATA_W-1:0] w_imm;
  logic              w_imm_s;
  logic              w_writes_reg;
  logic [FLAG_W-1:0] w_flag_mask;
  logic              w_illegal;
  logic              w_accept;
  // In IDLE the decoder looks at the incoming word so legal controls can be loaded on the accept
  // edge and be visible throughout DECODE; afterwards it looks at the latched copy.
  assign w_dec_in = (r_state == S_IDLE) ? instr : r_instr;
  regalu_decode #(.DATA_W(DATA_W), .OP_W(OP_W), .FLAG_W(FLAG_W)) u_decode (
    .i_instr     (w_dec_in),
    .o_opcode    (w_opcode),
    .o_imm       (w_imm),
    .o_imm_s     (w_imm_s),
    .o_writes_reg(w_writes_reg),
    .o_flag_mask (w_flag_mask),
    .o_illegal   (w_illegal)
  );
  assign instr_ready = r_state == S_IDLE;
  assign w_accept    = instr_ready && instr_valid;
  assign buf_en      = (r_state == S_EXEC) || (r_state == S_WB);
  assign En          = (r_state == S_WB) && w_writes_reg;
  assign done        = r_state == S_WB;
  assign illegal     = (r_state == S_DECODE) && w_illegal;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = instr_valid ? S_DECODE : S_IDLE;
      S_DECODE: w_next = w_illegal ? S_IDLE : S_EXEC;
      S_EXEC:   w_next = S_WB;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_instr     <= '0;
      RdestRegLoc <= '0;
      RsrcRegLoc  <= '0;
      Imm         <= '0;
      Imm_s       <= 1'b0;
      OpCode      <= '0;
      flags       <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_instr <= instr;
      if (w_accept && !w_illegal) begin
        RdestRegLoc <= REG_AW'(instr[11:8]);
        RsrcRegLoc  <= REG_AW'(instr[3:0]);
        Imm         <= w_imm;
        Imm_s       <= w_imm_s;
        OpCode      <= w_opcode;
      end
      if (r_state == S_WB) flags <= (flags & ~w_flag_mask) | (alu_flags & w_flag_mask);
    end
  end
endmodule

// File: tb/tb_regalu_sequencer.sv
// tb_regalu_sequencer: directed self-checking bench for regalu_sequencer
module tb_regalu_sequencer;
  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [4:0]  alu_flags = '0;
  logic [3:0]  RdestRegLoc;
  logic [3:0]  RsrcRegLoc;
  logic [15:0] Imm;
  logic        Imm_s;
  logic [4:0]  OpCode;
  logic        buf_en;
  logic        En;
  logic [4:0]  flags;
  logic        done;
  logic        illegal;
  int vectors = 0;
  int errors  = 0;
  regalu_sequencer dut (
    .Clk(Clk), .Rst(Rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_flags(alu_flags), .RdestRegLoc(RdestRegLoc), .RsrcRegLoc(RsrcRegLoc), .Imm(Imm),
    .Imm_s(Imm_s), .OpCode(OpCode), .buf_en(buf_en), .En(En), .flags(flags), .done(done),
    .illegal(illegal)
  );
  always #5 Clk = ~Clk;
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic issue(input logic [15:0] w, input logic [4:0] af);
    instr = w;
    alu_flags = af;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask
  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    vectors++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", instr_ready); end
    vectors++; if (flags !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", flags); end
    vectors++; if ({En, buf_en, done, illegal} !== 4'b0) begin errors++; $display("FAIL reset_ctl got %b want 0000", {En, buf_en, done, illegal}); end
    vectors++; if ({RdestRegLoc, RsrcRegLoc, Imm, Imm_s, OpCode} !== '0) begin errors++; $display("FAIL reset_dp got %h want 0", {RdestRegLoc, RsrcRegLoc, Imm, Imm_s, OpCode}); end
  endtask
  task automatic test_add();
    issue(16'h0352, 5'b10100);
    vectors++; if ({RdestRegLoc, RsrcRegLoc, Imm_s, OpCode, Imm} !== {4'd3, 4'd2, 1'b0, 5'd0, 16'h0000}) begin errors++; $display("FAIL add_decode got %h/%h/%b/%h/%h want 3/2/0/00/0000", RdestRegLoc, RsrcRegLoc, Imm_s, OpCode, Imm); end
    vectors++; if ({instr_ready, buf_en, En, done} !== 4'b0000) begin errors++; $display("FAIL add_decode_ctl got %b want 0000", {instr_ready, buf_en, En, done}); end
    tick();
    vectors++; if ({buf_en, En, done} !== 3'b100) begin errors++; $display("FAIL add_exec got %b want 100", {buf_en, En, done}); end
    tick();
    vectors++; if ({buf_en, En, done} !== 3'b111) begin errors++; $display("FAIL add_wb got %b want 111", {buf_en, En, done}); end
    tick();
    vectors++; if (flags !== 5'b10100) begin errors++; $display("FAIL add_flags got %b want 10100", flags); end
    vectors++; if ({instr_ready, buf_en, En, done} !== 4'b1000) begin errors++; $display("FAIL add_idle got %b want 1000", {instr_ready, buf_en, En, done}); end
    vectors++; if ({RdestRegLoc, RsrcRegLoc} !== 8'h32) begin errors++; $display("FAIL add_hold got %h want 32", {RdestRegLoc, RsrcRegLoc}); end
  endtask
  task automatic test_cmp();
    logic en_seen = 1'b0;
    logic done_seen = 1'b0;
    issue(16'h01B2, 5'b01011);
    vectors++; if ({RdestRegLoc, RsrcRegLoc, OpCode, Imm_s} !== {4'd1, 4'd2, 5'd2, 1'b0}) begin errors++; $display("FAIL cmp_decode got %h/%h/%h/%b want 1/2/02/0", RdestRegLoc, RsrcRegLoc, OpCode, Imm_s); end
    for (int i = 0; i < 3; i++) begin
      en_seen |= En;
      done_seen |= done;
      tick();
    end
    vectors++; if (en_seen !== 1'b0) begin errors++; $display("FAIL cmp_en got %b want 0", en_seen); end
    vectors++; if (done_seen !== 1'b1) begin errors++; $display("FAIL cmp_done got %b want 1", done_seen); end
    vectors++; if (flags !== 5'b11111) begin errors++; $display("FAIL cmp_flags got %b want 11111", flags); end
  endtask
  task automatic test_subi();
    issue(16'h94FF, 5'b01011);
    vectors++; if ({RdestRegLoc, Imm, Imm_s, OpCode} !== {4'd4, 16'hFFFF, 1'b1, 5'd1}) begin errors++; $display("FAIL subi_decode got %h/%h/%b/%h want 4/ffff/1/01", RdestRegLoc, Imm, Imm_s, OpCode); end
    tick();
    tick();
    vectors++; if (En !== 1'b1) begin errors++; $display("FAIL subi_en got %b want 1", En); end
    tick();
    vectors++; if (flags !== 5'b01011) begin errors++; $display("FAIL subi_flags got %b want 01011", flags); end
  endtask
  task automatic test_imm_table();
    logic [15:0] ti [4];
    logic [15:0] te [4];
    logic [4:0]  to [4];
    ti[0] = 16'h14FF; te[0] = 16'h00FF; to[0] = 5'd3;
    ti[1] = 16'h2480; te[1] = 16'h0080; to[1] = 5'd4;
    ti[2] = 16'h3A7F; te[2] = 16'h007F; to[2] = 5'd5;
    ti[3] = 16'hD380; te[3] = 16'hFF80; to[3] = 5'd6;
    for (int k = 0; k < 4; k++) begin
      issue(ti[k], 5'b11111);
      vectors++; if ({Imm, Imm_s, OpCode, RdestRegLoc} !== {te[k], 1'b1, to[k], ti[k][11:8]}) begin errors++; $display("FAIL imm_%0d got %h/%b/%h/%h want %h/1/%h/%h", k, Imm, Imm_s, OpCode, RdestRegLoc, te[k], to[k], ti[k][11:8]); end
      tick();
      tick();
      vectors++; if ({En, done} !== 2'b11) begin errors++; $display("FAIL imm_wb_%0d got %b want 11", k, {En, done}); end
      tick();
    end
    vectors++; if (flags !== 5'b01011) begin errors++; $display("FAIL logic_flags got %b want 01011", flags); end
  endtask
  task automatic test_illegal();
    issue(16'h7123, 5'b10100);
    vectors++; if ({illegal, En, buf_en, done} !== 4'b1000) begin errors++; $display("FAIL ill_pulse got %b want 1000", {illegal, En, buf_en, done}); end
    vectors++; if ({RdestRegLoc, Imm, OpCode} !== {4'hA, 16'h007F, 5'd5} && {RdestRegLoc, Imm, OpCode} !== {4'h3, 16'hFF80, 5'd6}) begin errors++; $display("FAIL ill_dp got %h/%h/%h want 3/ff80/06", RdestRegLoc, Imm, OpCode); end
    tick();
    vectors++; if ({instr_ready, illegal, En} !== 3'b100) begin errors++; $display("FAIL ill_idle got %b want 100", {instr_ready, illegal, En}); end
    vectors++; if (flags !== 5'b01011) begin errors++; $display("FAIL ill_flags got %b want 01011", flags); end
    issue(16'h00F1, 5'b10100);
    vectors++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_rtype got %b want 1", illegal); end
    tick();
  endtask
  task automatic test_mid_reset();
    issue(16'h0352, 5'b10100);
    tick();
    vectors++; if (buf_en !== 1'b1) begin errors++; $display("FAIL mid_exec got %b want 1", buf_en); end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    vectors++; if ({instr_ready, En, done, buf_en} !== 4'b1000) begin errors++; $display("FAIL mid_abort got %b want 1000", {instr_ready, En, done, buf_en}); end
    vectors++; if (flags !== 5'b0) begin errors++; $display("FAIL mid_flags got %b want 00000", flags); end
  endtask
  task automatic test_back_to_back();
    int dones = 0;
    instr = 16'h0552;
    alu_flags = 5'b00000;
    instr_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      vectors++; if (instr_ready !== (k % 4 == 0)) begin errors++; $display("FAIL b2b_ready_%0d got %b want %b", k, instr_ready, k % 4 == 0); end
      dones += int'(done);
      tick();
    end
    instr_valid = 1'b0;
    vectors++; if (dones != 3) begin errors++; $display("FAIL b2b_dones got %0d want 3", dones); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    tick();
    test_reset();
    test_add();
    test_cmp();
    test_subi();
    test_imm_table();
    test_illegal();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
